// File: rtl/demux_scan_pkg.sv
// Shared types and constants for the demux scan sequencer.
package demux_scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StActive = 2'd2
  } scan_state_e;

endpackage

// File: rtl/demux_next_chan.sv
// Priority search over the channel mask: lowest enabled index and next enabled index above cur.
module demux_next_chan
  import demux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [IDX_W-1:0]  cur,
  output logic [IDX_W-1:0]  next_idx,
  output logic              next_found,
  output logic [IDX_W-1:0]  first_idx
);

  // Descending walk so the last hit is the lowest qualifying index.
  always_comb begin
    next_idx   = '0;
    next_found = 1'b0;
    first_idx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_idx = IDX_W'(i);
        if (IDX_W'(i) > cur) begin
          next_idx   = IDX_W'(i);
          next_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/demux_scan_sequencer.sv
// Drives demux_1_8 strobe/select: scans enabled channels, dwell-timed pulses with a one-cycle gap.
module demux_scan_sequencer
  import demux_scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [NUM_CH-1:0]  mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               continuous,
  output logic               i_out,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               done
);

  scan_state_e        state_q;
  logic [NUM_CH-1:0]  mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               cont_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               i_out_q;
  logic [IDX_W-1:0]   sel_q;
  logic               busy_q;
  logic               done_q;

  logic [NUM_CH-1:0]  search_mask;
  logic [IDX_W-1:0]   next_idx;
  logic               next_found;
  logic [IDX_W-1:0]   first_idx;
  logic [DWELL_W-1:0] dwell_eff;

  // In IDLE the live mask picks the first channel, since it is latched on the same edge.
  assign search_mask = (state_q == StIdle) ? mask : mask_q;
  assign dwell_eff   = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;

  demux_next_chan u_next_chan (
    .mask       (search_mask),
    .cur        (sel_q),
    .next_idx   (next_idx),
    .next_found (next_found),
    .first_idx  (first_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mask_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
      i_out_q <= 1'b0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          i_out_q <= 1'b0;
          if (start && !stop) begin
            mask_q  <= mask;
            dwell_q <= dwell;
            cont_q  <= continuous;
            if (mask == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= StSetup;
              sel_q   <= first_idx;
              busy_q  <= 1'b1;
            end
          end
        end
        StSetup: begin
          if (stop) begin
            state_q <= StIdle;
            i_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= StActive;
            i_out_q <= 1'b1;
            cnt_q   <= dwell_eff;
          end
        end
        StActive: begin
          if (stop) begin
            state_q <= StIdle;
            i_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (cnt_q <= DWELL_W'(1)) begin
            i_out_q <= 1'b0;
            cnt_q   <= '0;
            if (next_found) begin
              state_q <= StSetup;
              sel_q   <= next_idx;
            end else if (cont_q) begin
              state_q <= StSetup;
              sel_q   <= first_idx;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          i_out_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign i_out = i_out_q;
  assign sel   = {1'b0, sel_q};
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// Directed bench for demux_scan_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_demux_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] mask;
  logic [7:0] dwell;
  logic       continuous;
  logic       i_out;
  logic [3:0] sel;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  demux_scan_sequencer #(
    .DWELL_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mask       (mask),
    .dwell      (dwell),
    .continuous (continuous),
    .i_out      (i_out),
    .sel        (sel),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares the full output vector for one cycle.
  task automatic chk_out(input string tag, input logic e_i, input logic [3:0] e_sel,
                         input logic e_busy, input logic e_done);
    chk({tag, ".i_out"}, 32'(i_out), 32'(e_i));
    chk({tag, ".sel"},   32'(sel),   32'(e_sel));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    chk({tag, ".done"},  32'(done),  32'(e_done));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    mask = '0; dwell = '0; continuous = 1'b0;

    @(negedge clk);
    chk_out("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic one-shot: mask 0000_0101, dwell 3.
    @(negedge clk);
    mask = 8'b0000_0101; dwell = 8'd3; continuous = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk_out("basic.c1", 1'b0, 4'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk_out($sformatf("basic.c%0d", c), 1'b1, 4'd0, 1'b1, 1'b0);
    end
    @(negedge clk);
    chk_out("basic.c5", 1'b0, 4'd2, 1'b1, 1'b0);
    for (int c = 6; c <= 8; c++) begin
      @(negedge clk);
      chk_out($sformatf("basic.c%0d", c), 1'b1, 4'd2, 1'b1, 1'b0);
    end
    @(negedge clk);
    chk_out("basic.c9", 1'b0, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    chk_out("basic.c10", 1'b0, 4'd2, 1'b0, 1'b0);

    // Empty mask: immediate done, never busy, sel holds.
    mask = 8'h00; dwell = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk_out("empty.c1", 1'b0, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    chk_out("empty.c2", 1'b0, 4'd2, 1'b0, 1'b0);

    // Continuous single channel, dwell 0 acts as 1, then stop.
    mask = 8'h80; dwell = 8'd0; continuous = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk_out("single.c1", 1'b0, 4'd7, 1'b1, 1'b0);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      chk_out($sformatf("single.c%0d", c), logic'(c % 2 == 0), 4'd7, 1'b1, 1'b0);
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk_out("single.stop", 1'b0, 4'd7, 1'b0, 1'b1);
    @(negedge clk);
    chk_out("single.after", 1'b0, 4'd7, 1'b0, 1'b0);

    // Continuous wrap 1,7,1,7 with a mid-scan mask change that must be ignored.
    mask = 8'b1000_0010; dwell = 8'd2; continuous = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk_out("wrap.c1", 1'b0, 4'd1, 1'b1, 1'b0);
    mask = 8'h01; dwell = 8'd9; continuous = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      chk_out($sformatf("wrap.c%0d", c), logic'(((c - 1) % 3) != 0),
              (((c - 1) / 3) % 2 == 1) ? 4'd7 : 4'd1, 1'b1, 1'b0);
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk_out("wrap.stop", 1'b0, 4'd1, 1'b0, 1'b1);

    // Start with stop in IDLE: no scan.
    mask = 8'hFF; dwell = 8'd1; continuous = 1'b0; start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk_out("prio.c1", 1'b0, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("prio.c2", 1'b0, 4'd1, 1'b0, 1'b0);

    // Start pulsed during ACTIVE is ignored.
    mask = 8'h01; dwell = 8'd3; continuous = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk_out("busy.c1", 1'b0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("busy.c2", 1'b1, 4'd0, 1'b1, 1'b0);
    start = 1'b1; mask = 8'h80;
    @(negedge clk); start = 1'b0;
    chk_out("busy.c3", 1'b1, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("busy.c4", 1'b1, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("busy.c5", 1'b0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk_out("busy.c6", 1'b0, 4'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an ACTIVE dwell.
    mask = 8'hFF; dwell = 8'd5; continuous = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk_out("areset.pre", 1'b1, 4'd1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("areset.now", 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("areset.held", 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_out("areset.after", 1'b0, 4'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
